// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   ctrl_state_e : controller FSM states (INIT, RUN, STALL), 2-bit encoding
//   FWD_*        : EX-stage ALU operand source selects
//   REG_ZERO     : hard-wired zero register; never a hazard or forward source
//   reg_match()  : nonzero 5-bit register equality used by all address compares
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } ctrl_state_e;

  localparam logic [1:0] FWD_BANK = 2'b00;  // operand from register bank
  localparam logic [1:0] FWD_MEM  = 2'b01;  // operand from buffer3 result
  localparam logic [1:0] FWD_WB   = 2'b10;  // operand from mux4 (WB) result

  localparam logic [4:0] REG_ZERO = 5'd0;

  // True when dst names a real register and equals src.
  function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
    return (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter used for the controller performance counters.
//   clk, rst_n : clock, asynchronous active-low reset (clears count)
//   inc        : count one event this cycle
//   clr        : synchronous clear, wins over inc
//   cnt        : current count, holds at all-ones once reached
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard / sequencing controller for the 5-stage pipeline
// (IF/b1/ID/b2/EX/b3/MEM/b4/WB).
//
// Build option: define FORWARD_EN to enable EX-stage operand forwarding;
// only load-use hazards then stall (always for one cycle). Without it, fwd_a/fwd_b
// are constant 00 and any RAW dependency on EX/MEM/WB stalls until the
// producer has left WB.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   id_rs, id_rt, id_uses_rt   source registers of the instruction in ID
//   ex_rs, ex_rt               source registers held in b2 (EX)
//   ex_aw, ex_regwrite, ex_er  EX destination, write enable, load flag
//   mem_aw, mem_regwrite       MEM destination / write enable (b3)
//   wb_aw, wb_regwrite         WB destination / write enable (b4)
//   mem_taken, mem_jump        branch taken / jump resolved in MEM
//   pc_en, b1_en               PC and buffer1 load enables
//   b1_flush..b3_flush         load a bubble into that buffer on the next edge
//   fwd_a, fwd_b               ALU operand source selects
//   stall_cnt, flush_cnt       saturating stall-cycle / redirect-event counters
//   state_dbg                  current FSM state (ctrl_state_e encoding)
//
// After reset the controller sits in INIT for INIT_CYC cycles with the PC frozen
// and b1..b3 flushed, since the pipeline buffers have no reset of their own.
// Outputs are combinational from state and inputs; only the state, the init
// counter and the perf counters are registered.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int INIT_CYC = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       ex_aw,
  input  logic             ex_regwrite,
  input  logic             ex_er,
  input  logic [4:0]       mem_aw,
  input  logic             mem_regwrite,
  input  logic [4:0]       wb_aw,
  input  logic             wb_regwrite,
  input  logic             mem_taken,
  input  logic             mem_jump,
  output logic             pc_en,
  output logic             b1_en,
  output logic             b1_flush,
  output logic             b2_flush,
  output logic             b3_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state_dbg
);

  localparam int INIT_W = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;

  ctrl_state_e       state_q;
  logic [INIT_W-1:0] init_cnt_q;

  logic       hazard;
  logic       redirect;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;

  // ID instruction reads register dst (rt only counts when actually used).
  function automatic logic rd_hit(input logic [4:0] dst);
    return reg_match(dst, id_rs) || (id_uses_rt && reg_match(dst, id_rt));
  endfunction

  assign redirect = mem_taken | mem_jump;

`ifdef FORWARD_EN
  // Only a load in EX cannot be forwarded in time; everything else is bypassed.
  assign hazard = ex_regwrite & ex_er & rd_hit(ex_aw);

  // MEM result is younger than WB, so it wins when both match.
  always_comb begin
    fwd_a_sel = FWD_BANK;
    fwd_b_sel = FWD_BANK;
    if (mem_regwrite && reg_match(mem_aw, ex_rs))     fwd_a_sel = FWD_MEM;
    else if (wb_regwrite && reg_match(wb_aw, ex_rs))  fwd_a_sel = FWD_WB;
    if (mem_regwrite && reg_match(mem_aw, ex_rt))     fwd_b_sel = FWD_MEM;
    else if (wb_regwrite && reg_match(wb_aw, ex_rt))  fwd_b_sel = FWD_WB;
  end
`else
  // No bypass paths: the ID instruction waits until no in-flight producer
  // of its sources remains in EX, MEM or WB.
  assign hazard = (ex_regwrite  & rd_hit(ex_aw))
                | (mem_regwrite & rd_hit(mem_aw))
                | (wb_regwrite  & rd_hit(wb_aw));

  assign fwd_a_sel = FWD_BANK;
  assign fwd_b_sel = FWD_BANK;

  // EX source fields and the load flag only matter for forwarding.
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{ex_rs, ex_rt, ex_er};
`endif

  // Output decode; a redirect squashes everything younger than MEM, including
  // an instruction that would otherwise be stalled.
  always_comb begin
    pc_en    = 1'b0;
    b1_en    = 1'b0;
    b1_flush = 1'b0;
    b2_flush = 1'b0;
    b3_flush = 1'b0;
    fwd_a    = FWD_BANK;
    fwd_b    = FWD_BANK;
    case (state_q)
      INIT: begin
        b1_flush = 1'b1;
        b2_flush = 1'b1;
        b3_flush = 1'b1;
      end
      default: begin
        fwd_a = fwd_a_sel;
        fwd_b = fwd_b_sel;
        if (redirect) begin
          pc_en    = 1'b1;
          b1_en    = 1'b1;
          b1_flush = 1'b1;
          b2_flush = 1'b1;
          b3_flush = 1'b1;
        end else if (hazard) begin
          b2_flush = 1'b1;  // hold IF/ID, bubble into EX
        end else begin
          pc_en = 1'b1;
          b1_en = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT;
      init_cnt_q <= INIT_W'(INIT_CYC - 1);
    end else begin
      case (state_q)
        INIT: begin
          if (init_cnt_q == '0) state_q <= RUN;
          else                  init_cnt_q <= init_cnt_q - 1'b1;
        end
        RUN, STALL: begin
          if (redirect)    state_q <= RUN;
          else if (hazard) state_q <= STALL;
          else             state_q <= RUN;
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign state_dbg = state_q;

  logic in_init;
  logic stall_inc;
  logic flush_inc;

  assign in_init   = (state_q == INIT);
  assign flush_inc = !in_init && redirect;
  assign stall_inc = !in_init && hazard && !redirect;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .clr   (in_init),
    .cnt   (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .clr   (in_init),
    .cnt   (flush_cnt)
  );

endmodule
